// File: rtl/alu_op_driver_if.sv
// -----------------------------------------------------------------------------
// alu_op_driver_if
// Signal bundle for alu_op_driver: request channel, ALU operand/result pins,
// response channel, busy flag and (with ALU_OP_DRIVER_STATS_EN) statistics.
//   slave  : view used by alu_op_driver itself
//   master : mirror view for the command source / ALU / response consumer
// Signals:
//   req_valid_i, req_ready_o, req_a_i, req_b_i, req_op_i  request handshake
//   alu_a_o, alu_b_o, alu_op_o                            registered ALU inputs
//   alu_result_i, alu_invalid_i                           ALU outputs
//   rsp_valid_o, rsp_ready_i, rsp_result_o, rsp_invalid_o response handshake
//   busy_o                                                not IDLE
//   op_count_o, invalid_count_o                           ALU_OP_DRIVER_STATS_EN only
// -----------------------------------------------------------------------------
interface alu_op_driver_if #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned OP_WIDTH = 4
`ifdef ALU_OP_DRIVER_STATS_EN
   , parameter int unsigned CNT_WIDTH = 8
`endif
);
   logic                req_valid_i;
   logic                req_ready_o;
   logic [WIDTH-1:0]    req_a_i;
   logic [WIDTH-1:0]    req_b_i;
   logic [OP_WIDTH-1:0] req_op_i;
   logic [WIDTH-1:0]    alu_a_o;
   logic [WIDTH-1:0]    alu_b_o;
   logic [OP_WIDTH-1:0] alu_op_o;
   logic [WIDTH-1:0]    alu_result_i;
   logic                alu_invalid_i;
   logic                rsp_valid_o;
   logic                rsp_ready_i;
   logic [WIDTH-1:0]    rsp_result_o;
   logic                rsp_invalid_o;
   logic                busy_o;
`ifdef ALU_OP_DRIVER_STATS_EN
   logic [CNT_WIDTH-1:0] op_count_o;
   logic [CNT_WIDTH-1:0] invalid_count_o;
`endif

   modport slave (
      input  req_valid_i, req_a_i, req_b_i, req_op_i,
      input  alu_result_i, alu_invalid_i, rsp_ready_i,
      output req_ready_o, alu_a_o, alu_b_o, alu_op_o,
      output rsp_valid_o, rsp_result_o, rsp_invalid_o, busy_o
`ifdef ALU_OP_DRIVER_STATS_EN
      , output op_count_o, invalid_count_o
`endif
   );

   modport master (
      output req_valid_i, req_a_i, req_b_i, req_op_i,
      output alu_result_i, alu_invalid_i, rsp_ready_i,
      input  req_ready_o, alu_a_o, alu_b_o, alu_op_o,
      input  rsp_valid_o, rsp_result_o, rsp_invalid_o, busy_o
`ifdef ALU_OP_DRIVER_STATS_EN
      , input op_count_o, invalid_count_o
`endif
   );
endinterface

// File: rtl/alu_op_driver.sv
// -----------------------------------------------------------------------------
// alu_op_driver
// Sequencing front end for a combinational ALU. Accepts a request, drives the
// registered operands/opcode onto the ALU, waits SETTLE cycles, samples the
// ALU result/invalid flag and offers it on a valid/ready response channel.
// Ports:
//   clk_i  system clock (rising edge)
//   rst_i  asynchronous active-high reset
//   bus    alu_op_driver_if.slave (request, ALU pins, response, busy)
// Optional: define ALU_OP_DRIVER_STATS_EN to add saturating op_count_o and
// invalid_count_o counters (CNT_WIDTH bits) on the interface.
// -----------------------------------------------------------------------------
module alu_op_driver #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned OP_WIDTH  = 4,
   parameter int unsigned SETTLE    = 1,
   parameter int unsigned CNT_WIDTH = 8
) (
   input  logic           clk_i,
   input  logic           rst_i,
   alu_op_driver_if.slave bus
);
   if (SETTLE < 1 || SETTLE > 15 || CNT_WIDTH < 1) begin : g_param_check
      $error("alu_op_driver: SETTLE must be 1..15 and CNT_WIDTH >= 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t              state, state_nx;
   logic [3:0]          cnt, cnt_nx;
   logic [WIDTH-1:0]    a_q, a_nx, b_q, b_nx;
   logic [OP_WIDTH-1:0] op_q, op_nx;
   logic [WIDTH-1:0]    res_q, res_nx;
   logic                inv_q, inv_nx;
   logic                vld_q, vld_nx;
   logic                accept, capture;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= S_IDLE;
         cnt   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= '0;
         res_q <= '0;
         inv_q <= 1'b0;
         vld_q <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         a_q   <= a_nx;
         b_q   <= b_nx;
         op_q  <= op_nx;
         res_q <= res_nx;
         inv_q <= inv_nx;
         vld_q <= vld_nx;
      end
   end

   assign accept  = (state == S_IDLE) && bus.req_valid_i;
   assign capture = (state == S_WAIT) && (cnt == '0);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      a_nx     = a_q;
      b_nx     = b_q;
      op_nx    = op_q;
      res_nx   = res_q;
      inv_nx   = inv_q;
      vld_nx   = vld_q;
      case (state)
         S_IDLE: begin
            if (accept) begin
               a_nx     = bus.req_a_i;
               b_nx     = bus.req_b_i;
               op_nx    = bus.req_op_i;
               cnt_nx   = 4'(SETTLE - 1);
               state_nx = S_WAIT;
            end
         end
         S_WAIT: begin
            if (capture) begin
               res_nx   = bus.alu_result_i;
               inv_nx   = bus.alu_invalid_i;
               vld_nx   = 1'b1;
               state_nx = S_RESP;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         S_RESP: begin
            if (bus.rsp_ready_i) begin
               vld_nx   = 1'b0;
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Ready is masked by reset so no request can appear accepted while held.
   assign bus.req_ready_o   = (state == S_IDLE) && !rst_i;
   assign bus.busy_o        = (state != S_IDLE);
   assign bus.alu_a_o       = a_q;
   assign bus.alu_b_o       = b_q;
   assign bus.alu_op_o      = op_q;
   assign bus.rsp_valid_o   = vld_q;
   assign bus.rsp_result_o  = res_q;
   assign bus.rsp_invalid_o = inv_q;

`ifdef ALU_OP_DRIVER_STATS_EN
   logic [CNT_WIDTH-1:0] op_cnt, inv_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         op_cnt  <= '0;
         inv_cnt <= '0;
      end else begin
         if (accept && op_cnt != '1)
            op_cnt <= op_cnt + 1'b1;
         if (capture && bus.alu_invalid_i && inv_cnt != '1)
            inv_cnt <= inv_cnt + 1'b1;
      end
   end

   assign bus.op_count_o      = op_cnt;
   assign bus.invalid_count_o = inv_cnt;
`endif
endmodule

// File: tb/tb_alu_op_driver.sv
// -----------------------------------------------------------------------------
// tb_alu_op_driver
// Directed bench for alu_op_driver: one instance with SETTLE=1 and one with
// SETTLE=3 share clock and reset. A small ALU model (add/sub/and/or, anything
// else flagged invalid with result 0) feeds each instance's result pins.
// -----------------------------------------------------------------------------
module tb_alu_op_driver;
   logic clk;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;

`ifdef ALU_OP_DRIVER_STATS_EN
   alu_op_driver_if #(.WIDTH(4), .OP_WIDTH(4), .CNT_WIDTH(8)) if1 ();
   alu_op_driver_if #(.WIDTH(4), .OP_WIDTH(4), .CNT_WIDTH(8)) if2 ();
`else
   alu_op_driver_if #(.WIDTH(4), .OP_WIDTH(4)) if1 ();
   alu_op_driver_if #(.WIDTH(4), .OP_WIDTH(4)) if2 ();
`endif

   alu_op_driver #(.WIDTH(4), .OP_WIDTH(4), .SETTLE(1), .CNT_WIDTH(8)) dut1 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (if1)
   );

   alu_op_driver #(.WIDTH(4), .OP_WIDTH(4), .SETTLE(3), .CNT_WIDTH(8)) dut3 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (if2)
   );

   function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] op);
      case (op)
         4'h0:    return {1'b0, a + b};
         4'h1:    return {1'b0, a - b};
         4'h2:    return {1'b0, a & b};
         4'h3:    return {1'b0, a | b};
         default: return {1'b1, 4'h0};
      endcase
   endfunction

   assign {if1.alu_invalid_i, if1.alu_result_i} = alu_fn(if1.alu_a_o, if1.alu_b_o, if1.alu_op_o);
   assign {if2.alu_invalid_i, if2.alu_result_i} = alu_fn(if2.alu_a_o, if2.alu_b_o, if2.alu_op_o);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0;
      if1.req_valid_i = 1'b0; if1.req_a_i = '0; if1.req_b_i = '0; if1.req_op_i = '0;
      if1.rsp_ready_i = 1'b1;
      if2.req_valid_i = 1'b0; if2.req_a_i = '0; if2.req_b_i = '0; if2.req_op_i = '0;
      if2.rsp_ready_i = 1'b1;

      // Asynchronous reset, observed before any clock edge
      #2 rst = 1'b1;
      #1;
      chk("rst_alu_a",     if1.alu_a_o, 0);
      chk("rst_alu_b",     if1.alu_b_o, 0);
      chk("rst_alu_op",    if1.alu_op_o, 0);
      chk("rst_rsp_valid", if1.rsp_valid_o, 0);
      chk("rst_rsp_res",   if1.rsp_result_o, 0);
      chk("rst_rsp_inv",   if1.rsp_invalid_o, 0);
      chk("rst_busy",      if1.busy_o, 0);
      chk("rst_ready",     if1.req_ready_o, 0);
`ifdef ALU_OP_DRIVER_STATS_EN
      chk("rst_op_cnt",    if1.op_count_o, 0);
`endif
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("ready_after_rst", if1.req_ready_o, 1);
      chk("ready_after_rst3", if2.req_ready_o, 1);

      // Basic add 3+5, SETTLE=1, consumer already ready
      if1.req_a_i = 4'd3; if1.req_b_i = 4'd5; if1.req_op_i = 4'h0; if1.req_valid_i = 1'b1;
      tick();
      if1.req_valid_i = 1'b0;
      chk("basic_alu_a",   if1.alu_a_o, 3);
      chk("basic_alu_b",   if1.alu_b_o, 5);
      chk("basic_busy",    if1.busy_o, 1);
      chk("basic_ready0",  if1.req_ready_o, 0);
      chk("basic_vld_early", if1.rsp_valid_o, 0);
      tick();
      chk("basic_vld",     if1.rsp_valid_o, 1);
      chk("basic_res",     if1.rsp_result_o, 8);
      chk("basic_inv",     if1.rsp_invalid_o, 0);
      tick();
      chk("basic_vld_drop", if1.rsp_valid_o, 0);
      chk("basic_idle",    if1.busy_o, 0);
      chk("basic_ready1",  if1.req_ready_o, 1);
      chk("basic_hold_a",  if1.alu_a_o, 3);

      // Back-pressure 7+6 with an ignored request pulse while held
      if1.rsp_ready_i = 1'b0;
      if1.req_a_i = 4'd7; if1.req_b_i = 4'd6; if1.req_op_i = 4'h0; if1.req_valid_i = 1'b1;
      tick();
      if1.req_valid_i = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_vld",   if1.rsp_valid_o, 1);
         chk("bp_res",   if1.rsp_result_o, 13);
         chk("bp_ready", if1.req_ready_o, 0);
         if (i == 2) begin
            if1.req_a_i = 4'd1; if1.req_b_i = 4'd1; if1.req_op_i = 4'h3; if1.req_valid_i = 1'b1;
         end else begin
            if1.req_valid_i = 1'b0;
         end
         tick();
      end
      if1.req_valid_i = 1'b0;
      chk("bp_ignored_a", if1.alu_a_o, 7);
      chk("bp_ignored_op", if1.alu_op_o, 0);
      if1.rsp_ready_i = 1'b1;
      tick();
      chk("bp_vld_drop", if1.rsp_valid_o, 0);
      chk("bp_idle",     if1.busy_o, 0);

      // Invalid opcode
      if1.req_a_i = 4'd1; if1.req_b_i = 4'd2; if1.req_op_i = 4'hF; if1.req_valid_i = 1'b1;
      tick();
      if1.req_valid_i = 1'b0;
      tick();
      chk("inv_vld", if1.rsp_valid_o, 1);
      chk("inv_flag", if1.rsp_invalid_o, 1);
      chk("inv_res", if1.rsp_result_o, 0);
      tick();
      chk("inv_idle", if1.busy_o, 0);
`ifdef ALU_OP_DRIVER_STATS_EN
      chk("stat_op_cnt3",  if1.op_count_o, 3);
      chk("stat_inv_cnt1", if1.invalid_count_o, 1);
`endif

      // SETTLE=3: 4+9 -> 13, response exactly after edge N+3
      if2.req_a_i = 4'd4; if2.req_b_i = 4'd9; if2.req_op_i = 4'h0; if2.req_valid_i = 1'b1;
      tick();
      if2.req_valid_i = 1'b0;
      chk("s3_busy", if2.busy_o, 1);
      chk("s3_vld_n0", if2.rsp_valid_o, 0);
      tick();
      chk("s3_vld_n1", if2.rsp_valid_o, 0);
      tick();
      chk("s3_vld_n2", if2.rsp_valid_o, 0);
      tick();
      chk("s3_vld_n3", if2.rsp_valid_o, 1);
      chk("s3_res",    if2.rsp_result_o, 13);
      tick();
      chk("s3_vld_drop", if2.rsp_valid_o, 0);

      // Reset while SETTLE=3 instance is in WAIT
      if2.req_a_i = 4'd5; if2.req_b_i = 4'd5; if2.req_op_i = 4'h0; if2.req_valid_i = 1'b1;
      tick();
      if2.req_valid_i = 1'b0;
      tick();
      #2 rst = 1'b1;
      #1;
      chk("mrst_busy",  if2.busy_o, 0);
      chk("mrst_alu_a", if2.alu_a_o, 0);
      chk("mrst_vld",   if2.rsp_valid_o, 0);
      chk("mrst_res",   if2.rsp_result_o, 0);
      chk("mrst_d1_a",  if1.alu_a_o, 0);
      #2 rst = 1'b0;
      tick();
      chk("mrst_no_stale", if2.rsp_valid_o, 0);
      tick(); tick(); tick();
      chk("mrst_no_stale2", if2.rsp_valid_o, 0);
      chk("mrst_idle",  if2.busy_o, 0);
`ifdef ALU_OP_DRIVER_STATS_EN
      chk("stat_op_clr",  if1.op_count_o, 0);
      chk("stat_inv_clr", if1.invalid_count_o, 0);
`endif
      if2.req_a_i = 4'd2; if2.req_b_i = 4'd2; if2.req_op_i = 4'h0; if2.req_valid_i = 1'b1;
      tick();
      if2.req_valid_i = 1'b0;
      tick();
      tick();
      chk("new_vld_early", if2.rsp_valid_o, 0);
      tick();
      chk("new_vld", if2.rsp_valid_o, 1);
      chk("new_res", if2.rsp_result_o, 4);
      tick();
      chk("new_idle", if2.busy_o, 0);

`ifdef ALU_OP_DRIVER_STATS_EN
      // 300 requests saturate the 8-bit operation counter
      if1.req_a_i = 4'd1; if1.req_b_i = 4'd1; if1.req_op_i = 4'h0;
      for (int i = 0; i < 300; i++) begin
         if1.req_valid_i = 1'b1;
         tick();
         if1.req_valid_i = 1'b0;
         tick();
         tick();
      end
      chk("stat_op_sat",  if1.op_count_o, 255);
      chk("stat_inv_zero", if1.invalid_count_o, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_op_driver.md
Name: alu_op_driver

Overview:
- Sequencing front end for the combinational ALU: accepts operation requests over a valid/ready handshake and drives them onto the ALU operand/opcode inputs.
- Waits a fixed settle time, then samples the ALU result and invalid flag.
- Returns the sampled result on a valid/ready response channel.
- Sits between a command source (testbench driver or control unit) and the ALU, so the ALU is always exercised with stable, registered inputs.

Parameters:
- WIDTH, 4, operand and result width; matches ALU a_i/b_i/result_o.
- OP_WIDTH, 4, opcode width; matches ALU op_i.
- SETTLE, 1, cycles from driving ALU inputs to sampling its outputs; legal range 1..15.
- CNT_WIDTH, 8, width of statistics counters (used only with the optional feature).

Ports:
- clk_i  input  1  system clock; all state changes on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  block can accept a request.
- req_a_i  input  WIDTH  operand A.
- req_b_i  input  WIDTH  operand B.
- req_op_i  input  OP_WIDTH  opcode.
- alu_a_o  output  WIDTH  registered operand A to ALU a_i.
- alu_b_o  output  WIDTH  registered operand B to ALU b_i.
- alu_op_o  output  OP_WIDTH  registered opcode to ALU op_i.
- alu_result_i  input  WIDTH  ALU result_o.
- alu_invalid_i  input  1  ALU invalid flag.
- rsp_valid_o  output  1  response valid.
- rsp_ready_i  input  1  consumer accepts response.
- rsp_result_o  output  WIDTH  captured result.
- rsp_invalid_o  output  1  captured invalid flag.
- busy_o  output  1  high whenever state is not IDLE.

Behaviour:
- Clocking and reset: one clock. Reset asynchronous, active-high (rst_i).
- Reset values:
  - state = IDLE.
  - alu_a_o, alu_b_o, alu_op_o, rsp_result_o = 0.
  - rsp_valid_o, rsp_invalid_o, busy_o = 0.
  - req_ready_o = 1 once rst_i deasserts.
  - Settle counter = 0.
- FSM states: IDLE, WAIT, RESP.
  - IDLE:
    - req_ready_o = 1.
    - On req_valid_i=1 at edge N: latch req_a_i/req_b_i/req_op_i into alu_*_o, load counter with SETTLE-1, go to WAIT.
  - WAIT:
    - req_ready_o = 0.
    - Counter decrements each cycle.
    - When counter = 0, at that edge capture alu_result_i and alu_invalid_i into rsp_result_o/rsp_invalid_o, assert rsp_valid_o, go to RESP.
  - RESP:
    - rsp_valid_o = 1 with rsp_result_o/rsp_invalid_o held stable until rsp_ready_i = 1.
    - On the handshake edge: rsp_valid_o to 0, go to IDLE.
    - rsp_ready_i may already be high when rsp_valid_o rises; the handshake then completes on the next edge.
- Latency:
  - Request accepted at edge N; ALU inputs change after N.
  - Sample at edge N+SETTLE; rsp_valid_o high after N+SETTLE.
  - Minimum request-to-request period is SETTLE+2 cycles.
- ALU inputs: alu_*_o hold the last issued values after capture and while IDLE. They change only on request acceptance.
- Request handling:
  - req_valid_i while not IDLE: ignored, not queued.
  - Requester must hold req_valid_i and its data until req_ready_o is seen.
- Data integrity:
  - Response data is never modified while rsp_valid_o = 1.
  - No arithmetic is performed on data; widths pass through unchanged.
- rst_i mid-operation (WAIT or RESP):
  - Immediate return to the reset values above.
  - Pending response is discarded; no response is produced for it.

Optional Feature:
- Macro: ALU_OP_DRIVER_STATS_EN.
- Defined:
  - Adds output op_count_o (CNT_WIDTH): increments on each request acceptance.
  - Adds output invalid_count_o (CNT_WIDTH): increments on each capture with alu_invalid_i = 1.
  - Both counters saturate at all-ones, clear on reset, and are valid one cycle after the triggering edge.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset check: assert rst_i asynchronously, no clock edge -> all outputs at reset values immediately; req_ready_o = 1 after release.
- Basic op, SETTLE=1: A=3, B=5, OP=add, rsp_ready_i=1 -> alu_a_o=3, alu_b_o=5 one edge after accept; rsp_valid_o after the next edge; rsp_result_o=8, rsp_invalid_o=0; back in IDLE after the handshake.
- Back-pressure: hold rsp_ready_i=0 for 5 cycles after rsp_valid_o -> rsp_valid_o/rsp_result_o stable and req_ready_o=0 throughout; a req_valid_i=1 pulse during that time is ignored.
- Invalid opcode: OP=4'hF with the ALU flagging invalid -> rsp_invalid_o=1. With ALU_OP_DRIVER_STATS_EN, invalid_count_o increments by 1.
- SETTLE=3: accept at edge N -> rsp_valid_o rises after edge N+3 and not earlier.
- Reset during WAIT, then a new request A=2, B=2, OP=add -> no stale response; the new response returns 4. With ALU_OP_DRIVER_STATS_EN, 300 requests leave op_count_o saturated at 255.
